score_conv_scheduler: RTL and testbench
=======================================

Name: score_conv_scheduler

Overview:
- Holds the two team scores of the scoreboard (0..MAX_SCORE) and applies single-cycle inc/dec/clear events to them.
- Time-shares one external binary-to-BCD converter instance between team A and team B. Each score is converted only when it has changed, and the BCD digits are latched into shadow registers.
- Scans the four latched digits (A tens, A ones, B tens, B ones) onto a multiplexed display bus.

Parameters:
- MAX_SCORE, 99, upper saturation limit of each score (must be ≤ 99).
- CONV_LAT, 1, converter latency in clocks from conv_bin_o change to valid conv_zehner_i/conv_einer_i (≥ 1).
- SCAN_DIV, 1000, clocks each display digit is held (≥ 2).

Ports:
- clk_i  in  1  system clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- inc_a_i  in  1  one-cycle pulse: team A score +1.
- dec_a_i  in  1  one-cycle pulse: team A score -1.
- inc_b_i  in  1  one-cycle pulse: team B score +1.
- dec_b_i  in  1  one-cycle pulse: team B score -1.
- clr_i  in  1  one-cycle pulse: both scores to 0.
- conv_bin_o  out  8  operand driven to the shared converter (registered).
- conv_zehner_i  in  4  converter tens digit.
- conv_einer_i  in  4  converter ones digit.
- score_a_o  out  7  current binary score A.
- score_b_o  out  7  current binary score B.
- busy_o  out  1  high while the scheduler FSM is not in IDLE.
- digit_sel_o  out  4  one-hot digit enable: bit0 = A tens, bit1 = A ones, bit2 = B tens, bit3 = B ones.
- digit_bcd_o  out  4  BCD value of the selected digit.

Behaviour:
- Reset (async, any time, including mid-conversion):
  - Scores 0, BCD shadows 0, dirty flags 0, FSM IDLE, conv_bin_o 0, busy_o 0.
  - Scan counter 0, digit_sel_o 4'b0001, digit_bcd_o 0.
- Score update, evaluated per team each clock:
  - clr_i has top priority: both scores become 0 and both dirty flags are set.
  - inc and dec of the same team in the same cycle: no change, dirty not set.
  - inc at MAX_SCORE holds MAX_SCORE. dec at 0 holds 0. A saturated event does not set dirty.
  - Otherwise the score becomes ±1 and that team's dirty flag is set. The new value is visible on score_x_o the next cycle.
- Scheduler FSM: IDLE, LOAD_A, WAIT_A, CAP_A, LOAD_B, WAIT_B, CAP_B.
  - IDLE: if dirty_a, go to LOAD_A; else if dirty_b, go to LOAD_B; else stay.
  - LOAD_x: conv_bin_o <= {1'b0, score_x}. Clear dirty_x in the same edge, unless a new event for x sets it again that cycle (set wins). Go to WAIT_x.
  - WAIT_x: hold for CONV_LAT cycles (internal counter), then go to CAP_x.
  - CAP_x: bcd_x_tens <= conv_zehner_i, bcd_x_ones <= conv_einer_i.
    - From CAP_A: if dirty_b, go to LOAD_B; else go to IDLE.
    - From CAP_B: go to IDLE.
  - A score change during a conversion re-sets dirty and triggers a fresh conversion afterwards. The stale result is still captured, then overwritten.
  - Single-team conversion, clean path: LOAD, WAIT×CONV_LAT, CAP = CONV_LAT + 2 clocks. The shadow register updates at the end of CAP.
  - conv_bin_o holds its value outside LOAD states.
- Display scan:
  - Prescaler counts 0..SCAN_DIV-1. On wrap, digit_sel_o rotates left (0001 → 0010 → 0100 → 1000 → 0001).
  - digit_bcd_o is registered and matches the shadow digit of the new selection in the same cycle as digit_sel_o.
  - The scan runs regardless of FSM state. Shadows only change in CAP, so each digit is always coherent.

Decomposition:
- Shared package: FSM state encoding (localparams for the 7 states), digit index constants, score width (7), BCD width (4).
- One natural sub-module, score_counter_sat: one per team. It holds the saturating 7-bit score and produces the dirty-set pulse.
- Scan logic stays inline. The converter is external and is not instantiated inside this block.

Test Plan:
- Reset, then 3× inc_a_i, with a converter model (CONV_LAT = 1) attached:
  - score_a_o = 3, busy_o pulses.
  - After the final CAP: A ones shadow = 3, A tens = 0.
  - With SCAN_DIV = 2, digit_bcd_o sequence is 0, 3, 0, 0.
- Preload A = 99, pulse inc_a_i → score stays 99, no dirty, busy_o stays 0. At B = 0, pulse dec_b_i → score stays 0, FSM stays in IDLE.
- inc_a_i and dec_a_i in the same cycle at A = 42 → A stays 42, no conversion.
  - Same cycle inc_b_i, A = 42 → B = 1.
  - Conversion order: B only; shadows B = 0/1.
- inc_a_i and inc_b_i in the same cycle, from 0 → FSM runs LOAD_A…CAP_A then LOAD_B…CAP_B back to back, 6 busy clocks total. Final shadows A = 0/1, B = 0/1.
- Pulse inc_a_i during WAIT_A (A: 57 → 58) → 5/7 is captured, then the FSM re-enters LOAD_A and the final shadow is 5/8.
- Assert rst_i during WAIT_B with B = 77 → outputs are 0 immediately (asynchronous). After release, the FSM is in IDLE, digit_sel_o = 0001, and clr_i does not need to be issued.

Source files
------------

// File: rtl/score_conv_scheduler_pkg.sv
// Shared types and constants for the score/convert/scan scheduler.
// Provides score and BCD widths, display digit indices and the
// scheduler FSM state type.
package score_conv_scheduler_pkg;

  localparam int unsigned SCORE_W = 7;
  localparam int unsigned BCD_W   = 4;

  // Bit positions inside the one-hot digit select
  localparam int unsigned DIG_A_TENS = 0;
  localparam int unsigned DIG_A_ONES = 1;
  localparam int unsigned DIG_B_TENS = 2;
  localparam int unsigned DIG_B_ONES = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_A,
    ST_WAIT_A,
    ST_CAP_A,
    ST_LOAD_B,
    ST_WAIT_B,
    ST_CAP_B
  } sched_state_t;

endpackage

// File: rtl/score_conv_scheduler_counter.sv
// Saturating per-team score counter.
// Ports:
//   clk_i, rst_i      clock, async active-high reset
//   inc_i, dec_i      one-cycle +1 / -1 requests
//   clr_i             one-cycle clear to 0 (top priority)
//   score_o           current score (0..MAX_SCORE)
//   dirty_set_o       high in any cycle whose event changes (or clears) the score
module score_counter_sat
  import score_conv_scheduler_pkg::*;
#(
  parameter int unsigned MAX_SCORE = 99
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               inc_i,
  input  logic               dec_i,
  input  logic               clr_i,
  output logic [SCORE_W-1:0] score_o,
  output logic               dirty_set_o
);

  logic [SCORE_W-1:0] r_score;
  logic               w_up;
  logic               w_dn;

  // Simultaneous inc/dec cancel; saturated moves are dropped silently.
  always_comb begin
    w_up        = inc_i && !dec_i && (r_score != SCORE_W'(MAX_SCORE));
    w_dn        = dec_i && !inc_i && (r_score != '0);
    dirty_set_o = clr_i || w_up || w_dn;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_score <= '0;
    end else if (clr_i) begin
      r_score <= '0;
    end else if (w_up) begin
      r_score <= r_score + SCORE_W'(1);
    end else if (w_dn) begin
      r_score <= r_score - SCORE_W'(1);
    end
  end

  assign score_o = r_score;

endmodule

// File: rtl/score_conv_scheduler.sv
// Scoreboard core: two saturating scores, one time-shared external
// binary-to-BCD converter, and a four-digit multiplexed display scan.
// Ports:
//   clk_i, rst_i                    clock, async active-high reset
//   inc_a_i/dec_a_i/inc_b_i/dec_b_i score events (one-cycle pulses)
//   clr_i                           clear both scores
//   conv_bin_o                      registered operand to the converter
//   conv_zehner_i, conv_einer_i     converter tens / ones result
//   score_a_o, score_b_o            binary scores
//   busy_o                          scheduler not idle
//   digit_sel_o, digit_bcd_o        one-hot digit enable and its BCD value
module score_conv_scheduler
  import score_conv_scheduler_pkg::*;
#(
  parameter int unsigned MAX_SCORE = 99,
  parameter int unsigned CONV_LAT  = 1,
  parameter int unsigned SCAN_DIV  = 1000
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_a_i,
  input  logic         dec_a_i,
  input  logic         inc_b_i,
  input  logic         dec_b_i,
  input  logic         clr_i,
  output logic [7:0]   conv_bin_o,
  input  logic [3:0]   conv_zehner_i,
  input  logic [3:0]   conv_einer_i,
  output logic [6:0]   score_a_o,
  output logic [6:0]   score_b_o,
  output logic         busy_o,
  output logic [3:0]   digit_sel_o,
  output logic [3:0]   digit_bcd_o
);

  localparam int unsigned WAIT_W = (CONV_LAT > 1) ? $clog2(CONV_LAT) : 1;
  localparam int unsigned SCAN_W = $clog2(SCAN_DIV);

  logic [SCORE_W-1:0] w_score_a, w_score_b;
  logic               w_set_a, w_set_b;
  logic               r_dirty_a, r_dirty_b;
  sched_state_t       r_state, w_state_next;
  logic [WAIT_W-1:0]  r_wait_cnt;
  logic               w_wait_done;
  logic [BCD_W-1:0]   r_a_tens, r_a_ones, r_b_tens, r_b_ones;
  logic [7:0]         r_conv_bin;
  logic [SCAN_W-1:0]  r_scan_cnt;
  logic               w_scan_wrap;
  logic [3:0]         r_sel, w_sel_next;
  logic [BCD_W-1:0]   r_bcd, w_bcd_next;

  score_counter_sat #(.MAX_SCORE(MAX_SCORE)) u_cnt_a (
    .clk_i(clk_i), .rst_i(rst_i), .inc_i(inc_a_i), .dec_i(dec_a_i), .clr_i(clr_i),
    .score_o(w_score_a), .dirty_set_o(w_set_a)
  );

  score_counter_sat #(.MAX_SCORE(MAX_SCORE)) u_cnt_b (
    .clk_i(clk_i), .rst_i(rst_i), .inc_i(inc_b_i), .dec_i(dec_b_i), .clr_i(clr_i),
    .score_o(w_score_b), .dirty_set_o(w_set_b)
  );

  assign w_wait_done = (r_wait_cnt == WAIT_W'(CONV_LAT - 1));

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (r_dirty_a)      w_state_next = ST_LOAD_A;
        else if (r_dirty_b) w_state_next = ST_LOAD_B;
      end
      ST_LOAD_A: w_state_next = ST_WAIT_A;
      ST_WAIT_A: if (w_wait_done) w_state_next = ST_CAP_A;
      ST_CAP_A:  w_state_next = r_dirty_b ? ST_LOAD_B : ST_IDLE;
      ST_LOAD_B: w_state_next = ST_WAIT_B;
      ST_WAIT_B: if (w_wait_done) w_state_next = ST_CAP_B;
      ST_CAP_B:  w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= ST_IDLE;
      r_dirty_a  <= 1'b0;
      r_dirty_b  <= 1'b0;
      r_wait_cnt <= '0;
      r_conv_bin <= '0;
      r_a_tens   <= '0;
      r_a_ones   <= '0;
      r_b_tens   <= '0;
      r_b_ones   <= '0;
    end else begin
      r_state <= w_state_next;

      // A new event in the LOAD cycle must survive the clear (set wins).
      if (w_set_a)                    r_dirty_a <= 1'b1;
      else if (r_state == ST_LOAD_A)  r_dirty_a <= 1'b0;
      if (w_set_b)                    r_dirty_b <= 1'b1;
      else if (r_state == ST_LOAD_B)  r_dirty_b <= 1'b0;

      if (r_state == ST_WAIT_A || r_state == ST_WAIT_B) r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
      else                                              r_wait_cnt <= '0;

      if (r_state == ST_LOAD_A) r_conv_bin <= {1'b0, w_score_a};
      if (r_state == ST_LOAD_B) r_conv_bin <= {1'b0, w_score_b};

      if (r_state == ST_CAP_A) begin
        r_a_tens <= conv_zehner_i;
        r_a_ones <= conv_einer_i;
      end
      if (r_state == ST_CAP_B) begin
        r_b_tens <= conv_zehner_i;
        r_b_ones <= conv_einer_i;
      end
    end
  end

  // Display scan: the digit register is loaded from the selection that will
  // be current after this edge, so select and value always change together.
  assign w_scan_wrap = (r_scan_cnt == SCAN_W'(SCAN_DIV - 1));

  always_comb begin
    w_sel_next = w_scan_wrap ? {r_sel[2:0], r_sel[3]} : r_sel;
    w_bcd_next = '0;
    if (w_sel_next[DIG_A_TENS])      w_bcd_next = r_a_tens;
    else if (w_sel_next[DIG_A_ONES]) w_bcd_next = r_a_ones;
    else if (w_sel_next[DIG_B_TENS]) w_bcd_next = r_b_tens;
    else if (w_sel_next[DIG_B_ONES]) w_bcd_next = r_b_ones;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_scan_cnt <= '0;
      r_sel      <= 4'b0001;
      r_bcd      <= '0;
    end else begin
      r_scan_cnt <= w_scan_wrap ? '0 : r_scan_cnt + SCAN_W'(1);
      r_sel      <= w_sel_next;
      r_bcd      <= w_bcd_next;
    end
  end

  assign conv_bin_o  = r_conv_bin;
  assign score_a_o   = w_score_a;
  assign score_b_o   = w_score_b;
  assign busy_o      = (r_state != ST_IDLE);
  assign digit_sel_o = r_sel;
  assign digit_bcd_o = r_bcd;

endmodule

// File: tb/tb_score_conv_scheduler.sv
module tb_score_conv_scheduler;

  localparam int unsigned L    = 1;
  localparam int unsigned SD   = 2;
  localparam int unsigned MAXS = 99;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       inc_a = 1'b0, dec_a = 1'b0, inc_b = 1'b0, dec_b = 1'b0, clr = 1'b0;
  logic [7:0] conv_bin;
  logic [3:0] conv_z, conv_e;
  logic [6:0] score_a, score_b;
  logic       busy;
  logic [3:0] dsel, dbcd;

  int errors = 0;
  int checks = 0;
  int busy_cnt = 0;
  int m_a = 0;
  int m_b = 0;

  always #5 clk = ~clk;

  score_conv_scheduler #(.MAX_SCORE(MAXS), .CONV_LAT(L), .SCAN_DIV(SD)) dut (
    .clk_i(clk), .rst_i(rst),
    .inc_a_i(inc_a), .dec_a_i(dec_a), .inc_b_i(inc_b), .dec_b_i(dec_b), .clr_i(clr),
    .conv_bin_o(conv_bin), .conv_zehner_i(conv_z), .conv_einer_i(conv_e),
    .score_a_o(score_a), .score_b_o(score_b), .busy_o(busy),
    .digit_sel_o(dsel), .digit_bcd_o(dbcd)
  );

  // External converter model: arithmetic BCD split, delayed by L clocks.
  logic [7:0] pipe [L];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(L); i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= conv_bin;
      for (int i = 1; i < int'(L); i++) pipe[i] <= pipe[i-1];
    end
  end
  assign conv_z = 4'(pipe[L-1] / 8'd10);
  assign conv_e = 4'(pipe[L-1] % 8'd10);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      if (busy) busy_cnt++;
    end
  endtask

  // One event cycle; model applies the scoring rules, then scores are checked.
  task automatic ev(input bit ia, input bit da, input bit ib, input bit db, input bit cl);
    inc_a = ia; dec_a = da; inc_b = ib; dec_b = db; clr = cl;
    if (cl) begin
      m_a = 0; m_b = 0;
    end else begin
      if (ia && !da && m_a < int'(MAXS)) m_a++;
      else if (da && !ia && m_a > 0) m_a--;
      if (ib && !db && m_b < int'(MAXS)) m_b++;
      else if (db && !ib && m_b > 0) m_b--;
    end
    @(negedge clk);
    if (busy) busy_cnt++;
    inc_a = 0; dec_a = 0; inc_b = 0; dec_b = 0; clr = 0;
    chk("score_a", 32'(score_a), 32'(m_a));
    chk("score_b", 32'(score_b), 32'(m_b));
  endtask

  // Watch one full scan rotation and compare every digit with the model.
  task automatic read_display(input string tag);
    int dig [4];
    int bad_sel;
    bad_sel = 0;
    for (int i = 0; i < 4; i++) dig[i] = -1;
    repeat (4 * SD) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      case (dsel)
        4'b0001: dig[0] = int'(dbcd);
        4'b0010: dig[1] = int'(dbcd);
        4'b0100: dig[2] = int'(dbcd);
        4'b1000: dig[3] = int'(dbcd);
        default: bad_sel++;
      endcase
    end
    chk({tag, "_sel_onehot"}, 32'(bad_sel), 32'd0);
    chk({tag, "_a_tens"}, 32'(dig[0]), 32'(m_a / 10));
    chk({tag, "_a_ones"}, 32'(dig[1]), 32'(m_a % 10));
    chk({tag, "_b_tens"}, 32'(dig[2]), 32'(m_b / 10));
    chk({tag, "_b_ones"}, 32'(dig[3]), 32'(m_b % 10));
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    chk("rst_score_a", 32'(score_a), 32'd0);
    chk("rst_score_b", 32'(score_b), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_conv_bin", 32'(conv_bin), 32'd0);
    chk("rst_sel", 32'(dsel), 32'b0001);
    chk("rst_bcd", 32'(dbcd), 32'd0);
    rst = 0;

    // Three increments of A
    busy_cnt = 0;
    repeat (3) ev(1, 0, 0, 0, 0);
    idle(20);
    chk("inc3_busy_seen", 32'(busy_cnt != 0), 32'd1);
    chk("inc3_conv_bin", 32'(conv_bin), 32'd3);
    read_display("inc3");

    // Saturation at MAX and at 0
    while (m_a < int'(MAXS)) ev(1, 0, 0, 0, 0);
    idle(20);
    busy_cnt = 0;
    ev(1, 0, 0, 0, 0);
    idle(10);
    chk("sat_max_busy", 32'(busy_cnt), 32'd0);
    ev(0, 0, 0, 1, 0);
    idle(10);
    chk("sat_zero_busy", 32'(busy_cnt), 32'd0);
    read_display("sat");

    // inc+dec of A cancels; B converts alone
    while (m_a > 42) ev(0, 1, 0, 0, 0);
    idle(20);
    busy_cnt = 0;
    ev(1, 1, 1, 0, 0);
    idle(20);
    chk("cancel_busy", 32'(busy_cnt), 32'(L + 2));
    read_display("cancel");

    // Both teams in one cycle: back-to-back conversions
    ev(0, 0, 0, 0, 1);
    idle(20);
    busy_cnt = 0;
    ev(1, 0, 1, 0, 0);
    idle(20);
    chk("both_busy", 32'(busy_cnt), 32'(2 * (L + 2)));
    read_display("both");

    // Score change while converting A: stale capture, then reconversion
    while (m_a < 56) ev(1, 0, 0, 0, 0);
    idle(20);
    busy_cnt = 0;
    ev(1, 0, 0, 0, 0);   // 57, dirty set
    idle(1);             // LOAD_A
    idle(1);             // WAIT_A
    ev(1, 0, 0, 0, 0);   // 58 during WAIT_A
    idle(20);
    chk("midconv_busy", 32'(busy_cnt), 32'(2 * (L + 2)));
    read_display("midconv");

    // Random traffic against the model
    for (int i = 0; i < 300; i++) begin
      ev(($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
         ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
         ($urandom_range(0, 60) == 0));
    end
    idle(20);
    read_display("rand");

    // Async reset during WAIT_B
    ev(0, 0, 0, 0, 1);
    while (m_b < 76) ev(0, 0, 1, 0, 0);
    idle(20);
    ev(0, 0, 1, 0, 0);   // 77
    idle(1);             // LOAD_B
    idle(1);             // WAIT_B
    chk("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1;
    #1;
    m_a = 0; m_b = 0;
    chk("arst_score_b", 32'(score_b), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_conv_bin", 32'(conv_bin), 32'd0);
    chk("arst_sel", 32'(dsel), 32'b0001);
    chk("arst_bcd", 32'(dbcd), 32'd0);
    @(negedge clk);
    rst = 0;
    chk("post_rst_sel", 32'(dsel), 32'b0001);
    busy_cnt = 0;
    idle(10);
    chk("post_rst_busy", 32'(busy_cnt), 32'd0);
    read_display("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
